// File: rtl/pic_decode_seq.sv
// Instruction decoder and Q1-Q4 phase sequencer for the 12-bit PIC baseline core.
// Latches each instruction, drives ALU controls and issues phase-aligned datapath strobes.
module pic_decode_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] instr,
  input  logic        alu_zero,
  output logic [1:0]  q_phase,
  output logic [3:0]  alu_op,
  output logic        alu_b_sel,
  output logic [7:0]  alu_lit,
  output logic [4:0]  file_addr,
  output logic        file_rd,
  output logic        file_we,
  output logic        w_we,
  output logic        z_we,
  output logic        c_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [8:0]  pc_target,
  output logic        stack_push,
  output logic        stack_pop,
  output logic        flushing
);

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4,
    OP_COM = 4'd5, OP_ROR = 4'd6, OP_ROL = 4'd7, OP_SWAP = 4'd8,
    OP_BITCLR = 4'd9, OP_BITSET = 4'd10, OP_BTCLR = 4'd11, OP_BTSET = 4'd12,
    OP_PASSA = 4'd13, OP_PASSB = 4'd14
  } alu_op_t;

  phase_t      phase, phase_next;
  logic [11:0] ir;
  logic        flush;

  alu_op_t     op;
  logic        b_sel, dest, rd_f, we_f, we_w, upd_z, upd_c;
  logic        load, push, pop, skip_instr;
  logic [7:0]  lit;
  logic [8:0]  target;
  logic [7:0]  bit_lit;
  logic        live;

  assign bit_lit = {ir[7:5], 5'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= Q1;
      ir    <= 12'h000;
      flush <= 1'b0;
    end else begin
      phase <= phase_next;
      if (phase == Q1) ir <= instr;
      // A flushed slot can never start another flush, so back-to-back skips collapse.
      if (phase == Q4) flush <= !flush && (load || (skip_instr && alu_zero));
    end
  end

  always_comb begin
    phase_next = Q1;
    case (phase)
      Q1:      phase_next = Q2;
      Q2:      phase_next = Q3;
      Q3:      phase_next = Q4;
      Q4:      phase_next = Q1;
      default: phase_next = Q1;
    endcase
  end

  always_comb begin
    op = OP_PASSA; b_sel = 1'b0; lit = 8'h00; dest = 1'b0; rd_f = 1'b0;
    we_f = 1'b0; we_w = 1'b0; upd_z = 1'b0; upd_c = 1'b0;
    load = 1'b0; push = 1'b0; pop = 1'b0; skip_instr = 1'b0; target = 9'h000;
    casez (ir)
      12'b0000_001?_????: begin op = OP_PASSB; we_f = 1'b1; end
      12'b0000_01??_????: begin op = OP_AND; b_sel = 1'b1; dest = 1'b1; upd_z = 1'b1; end
      12'b0000_10??_????: begin op = OP_SUB; dest = 1'b1; rd_f = 1'b1; upd_z = 1'b1; upd_c = 1'b1; end
      12'b0000_11??_????: begin op = OP_SUB; b_sel = 1'b1; lit = 8'h01; dest = 1'b1; rd_f = 1'b1; upd_z = 1'b1; end
      12'b0001_00??_????: begin op = OP_OR;  dest = 1'b1; rd_f = 1'b1; upd_z = 1'b1; end
      12'b0001_01??_????: begin op = OP_AND; dest = 1'b1; rd_f = 1'b1; upd_z = 1'b1; end
      12'b0001_10??_????: begin op = OP_XOR; dest = 1'b1; rd_f = 1'b1; upd_z = 1'b1; end
      12'b0001_11??_????: begin op = OP_ADD; dest = 1'b1; rd_f = 1'b1; upd_z = 1'b1; upd_c = 1'b1; end
      12'b0010_00??_????: begin op = OP_PASSA; dest = 1'b1; rd_f = 1'b1; upd_z = 1'b1; end
      12'b0010_01??_????: begin op = OP_COM; dest = 1'b1; rd_f = 1'b1; upd_z = 1'b1; end
      12'b0010_10??_????: begin op = OP_ADD; b_sel = 1'b1; lit = 8'h01; dest = 1'b1; rd_f = 1'b1; upd_z = 1'b1; end
      12'b0010_11??_????: begin op = OP_SUB; b_sel = 1'b1; lit = 8'h01; dest = 1'b1; rd_f = 1'b1; skip_instr = 1'b1; end
      12'b0011_00??_????: begin op = OP_ROR; dest = 1'b1; rd_f = 1'b1; upd_c = 1'b1; end
      12'b0011_01??_????: begin op = OP_ROL; dest = 1'b1; rd_f = 1'b1; upd_c = 1'b1; end
      12'b0011_10??_????: begin op = OP_SWAP; dest = 1'b1; rd_f = 1'b1; end
      12'b0011_11??_????: begin op = OP_ADD; b_sel = 1'b1; lit = 8'h01; dest = 1'b1; rd_f = 1'b1; skip_instr = 1'b1; end
      12'b0100_????_????: begin op = OP_BITCLR; b_sel = 1'b1; lit = bit_lit; rd_f = 1'b1; we_f = 1'b1; end
      12'b0101_????_????: begin op = OP_BITSET; b_sel = 1'b1; lit = bit_lit; rd_f = 1'b1; we_f = 1'b1; end
      12'b0110_????_????: begin op = OP_BTCLR; b_sel = 1'b1; lit = bit_lit; rd_f = 1'b1; skip_instr = 1'b1; end
      12'b0111_????_????: begin op = OP_BTSET; b_sel = 1'b1; lit = bit_lit; rd_f = 1'b1; skip_instr = 1'b1; end
      // RETLW leaves pc_target at zero; the return stack supplies the address.
      12'b1000_????_????: begin op = OP_PASSB; b_sel = 1'b1; lit = ir[7:0]; we_w = 1'b1; load = 1'b1; pop = 1'b1; end
      12'b1001_????_????: begin load = 1'b1; push = 1'b1; target = {1'b0, ir[7:0]}; end
      12'b101?_????_????: begin load = 1'b1; target = ir[8:0]; end
      12'b1100_????_????: begin op = OP_PASSB; b_sel = 1'b1; lit = ir[7:0]; we_w = 1'b1; end
      12'b1101_????_????: begin op = OP_OR;  b_sel = 1'b1; lit = ir[7:0]; we_w = 1'b1; upd_z = 1'b1; end
      12'b1110_????_????: begin op = OP_AND; b_sel = 1'b1; lit = ir[7:0]; we_w = 1'b1; upd_z = 1'b1; end
      12'b1111_????_????: begin op = OP_XOR; b_sel = 1'b1; lit = ir[7:0]; we_w = 1'b1; upd_z = 1'b1; end
      default: ;
    endcase
    if (dest) begin
      we_f = ir[5];
      we_w = !ir[5];
    end
  end

  // Q4 side effects are suppressed while the slot is flushed; the PC still advances.
  assign live       = (phase == Q4) && !flush;
  assign file_rd    = (phase == Q2) && rd_f;
  assign file_we    = live && we_f;
  assign w_we       = live && we_w;
  assign z_we       = live && upd_z;
  assign c_we       = live && upd_c;
  assign pc_load    = live && load;
  assign pc_inc     = (phase == Q4) && !pc_load;
  assign stack_push = live && push;
  assign stack_pop  = live && pop;
  assign pc_target  = target;
  assign q_phase    = phase;
  assign alu_op     = op;
  assign alu_b_sel  = b_sel;
  assign alu_lit    = lit;
  assign file_addr  = ir[4:0];
  assign flushing   = flush;

endmodule

// File: tb/tb_pic_decode_seq.sv
// Directed, table-driven bench for pic_decode_seq: one table row per instruction cycle,
// plus hand-written reset-abort and flush-clear sequences.
module tb_pic_decode_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] instr;
   logic        aluZero;
   logic [1:0]  qPhase;
   logic [3:0]  aluOp;
   logic        aluBSel;
   logic [7:0]  aluLit;
   logic [4:0]  fileAddr;
   logic        fileRd, fileWe, wWe, zWe, cWe, pcInc, pcLoad, stackPush, stackPop, flushingOut;
   logic [8:0]  pcTarget;
   logic [8:0]  strbNow;

   int checks = 0;
   int errors = 0;

   // One instruction cycle: inputs, then expected Q2 read, Q3 ALU controls, Q4 strobes and target.
   // strb order is {file_we,w_we,z_we,c_we,pc_inc,pc_load,stack_push,stack_pop,flushing}.
   typedef struct packed {
      logic [11:0] instr;
      logic        zero;
      logic        rd;
      logic [3:0]  op;
      logic        bsel;
      logic [7:0]  lit;
      logic [4:0]  addr;
      logic [8:0]  strb;
      logic [8:0]  target;
   } vec_t;

   vec_t vecs[20];

   pic_decode_seq dut (
      .clk(clk), .rst(rst), .instr(instr), .alu_zero(aluZero),
      .q_phase(qPhase), .alu_op(aluOp), .alu_b_sel(aluBSel), .alu_lit(aluLit),
      .file_addr(fileAddr), .file_rd(fileRd), .file_we(fileWe), .w_we(wWe),
      .z_we(zWe), .c_we(cWe), .pc_inc(pcInc), .pc_load(pcLoad),
      .pc_target(pcTarget), .stack_push(stackPush), .stack_pop(stackPop),
      .flushing(flushingOut)
   );

   always #5 clk = ~clk;

   assign strbNow = {fileWe, wWe, zWe, cWe, pcInc, pcLoad, stackPush, stackPop, flushingOut};

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Called at Q1 (just after the edge); runs the full four-phase cycle and returns at the next Q1.
   task automatic applyStimulus(input vec_t v, input int idx);
      instr   = v.instr;
      aluZero = v.zero;
      @(posedge clk); #1;
      checkOutput($sformatf("row%0d_q2_phase_rd", idx), {30'd0, qPhase, fileRd} >> 0, {29'd0, 2'd1, v.rd});
      @(posedge clk); #1;
      checkOutput($sformatf("row%0d_q3_ctrl", idx), {14'd0, aluOp, aluBSel, aluLit, fileAddr},
                  {14'd0, v.op, v.bsel, v.lit, v.addr});
      checkOutput($sformatf("row%0d_q3_quiet", idx), {23'd0, strbNow[8:1], fileRd}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("row%0d_q4_strb", idx), {23'd0, strbNow}, {23'd0, v.strb});
      checkOutput($sformatf("row%0d_q4_target", idx), {23'd0, pcTarget}, {23'd0, v.target});
      @(posedge clk); #1;
   endtask

   initial begin
      //               instr  zero rd  op  bsel lit    addr   strb          target
      vecs[0]  = '{12'h1E7, 1'b0, 1'b1, 4'd0,  1'b0, 8'h00, 5'h07, 9'b101110000, 9'h000}; // ADDWF 7,1
      vecs[1]  = '{12'h643, 1'b1, 1'b1, 4'd11, 1'b1, 8'h40, 5'h03, 9'b000010000, 9'h000}; // BTFSC skip
      vecs[2]  = '{12'hC55, 1'b0, 1'b0, 4'd14, 1'b1, 8'h55, 5'h15, 9'b000010001, 9'h000}; // flushed MOVLW
      vecs[3]  = '{12'h643, 1'b0, 1'b1, 4'd11, 1'b1, 8'h40, 5'h03, 9'b000010000, 9'h000}; // BTFSC no skip
      vecs[4]  = '{12'hC55, 1'b0, 1'b0, 4'd14, 1'b1, 8'h55, 5'h15, 9'b010010000, 9'h000}; // MOVLW
      vecs[5]  = '{12'hB23, 1'b0, 1'b0, 4'd13, 1'b0, 8'h00, 5'h03, 9'b000001000, 9'h123}; // GOTO
      vecs[6]  = '{12'h1E7, 1'b0, 1'b1, 4'd0,  1'b0, 8'h00, 5'h07, 9'b000010001, 9'h000}; // flushed ADDWF
      vecs[7]  = '{12'h945, 1'b0, 1'b0, 4'd13, 1'b0, 8'h00, 5'h05, 9'b000001100, 9'h045}; // CALL
      vecs[8]  = '{12'h000, 1'b0, 1'b0, 4'd13, 1'b0, 8'h00, 5'h00, 9'b000010001, 9'h000}; // flushed NOP
      vecs[9]  = '{12'h83C, 1'b0, 1'b0, 4'd14, 1'b1, 8'h3C, 5'h1C, 9'b010001010, 9'h000}; // RETLW
      vecs[10] = '{12'h2F0, 1'b1, 1'b1, 4'd1,  1'b1, 8'h01, 5'h10, 9'b000010001, 9'h000}; // DECFSZ in flushed slot
      vecs[11] = '{12'h2F0, 1'b1, 1'b1, 4'd1,  1'b1, 8'h01, 5'h10, 9'b100010000, 9'h000}; // DECFSZ skip
      vecs[12] = '{12'h643, 1'b1, 1'b1, 4'd11, 1'b1, 8'h40, 5'h03, 9'b000010001, 9'h000}; // BTFSC in flushed slot
      vecs[13] = '{12'hC55, 1'b0, 1'b0, 4'd14, 1'b1, 8'h55, 5'h15, 9'b010010000, 9'h000}; // MOVLW not flushed
      vecs[14] = '{12'h03E, 1'b0, 1'b0, 4'd14, 1'b0, 8'h00, 5'h1E, 9'b100010000, 9'h000}; // MOVWF
      vecs[15] = '{12'h325, 1'b0, 1'b1, 4'd6,  1'b0, 8'h00, 5'h05, 9'b100110000, 9'h000}; // RRF 5,1
      vecs[16] = '{12'h040, 1'b0, 1'b0, 4'd2,  1'b1, 8'h00, 5'h00, 9'b011010000, 9'h000}; // CLRW
      vecs[17] = '{12'hE0F, 1'b0, 1'b0, 4'd2,  1'b1, 8'h0F, 5'h0F, 9'b011010000, 9'h000}; // ANDLW
      vecs[18] = '{12'h2A9, 1'b0, 1'b1, 4'd0,  1'b1, 8'h01, 5'h09, 9'b101010000, 9'h000}; // INCF 9,1
      vecs[19] = '{12'h004, 1'b0, 1'b0, 4'd13, 1'b0, 8'h00, 5'h04, 9'b000010000, 9'h000}; // undefined

      // Reset state.
      rst = 1'b1; instr = 12'h000; aluZero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_phase", {30'd0, qPhase}, 32'd0);
      checkOutput("reset_strb", {22'd0, strbNow, fileRd}, 32'd0);
      checkOutput("reset_ctrl", {14'd0, aluOp, aluBSel, aluLit, fileAddr}, {14'd0, 4'd13, 1'b0, 8'h00, 5'h00});
      checkOutput("reset_target", {23'd0, pcTarget}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) applyStimulus(vecs[i], i);

      // Reset asserted in Q3 of ADDWF aborts it: no Q4 writes, IR back to NOP.
      instr = 12'h1E7; aluZero = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("abort_q3_addr", {27'd0, fileAddr}, 32'h07);
      rst = 1'b1; instr = 12'h000;
      @(posedge clk); #1;
      checkOutput("abort_phase", {30'd0, qPhase}, 32'd0);
      checkOutput("abort_ir_nop", {23'd0, aluOp, fileAddr}, {23'd0, 4'd13, 5'h00});
      checkOutput("abort_strb", {22'd0, strbNow, fileRd}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_next_q2", {30'd0, qPhase}, 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("abort_next_q4", {23'd0, strbNow}, {23'd0, 9'b000010000});
      @(posedge clk); #1;

      // Reset during a flushed slot clears the flush flag.
      applyStimulus(vecs[5], 100);
      checkOutput("flush_set_q1", {31'd0, flushingOut}, 32'd1);
      instr = 12'hC55;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("flush_cleared", {30'd0, qPhase, flushingOut}, 32'd0);
      rst = 1'b0;
      applyStimulus(vecs[4], 101);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
